// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder: WIDTH bits split into STAGES registered CLA segments
// with valid/ready flow control. Define CLA_PIPE_SUB_EN to add the subtract-mode port 'sub'.
module cla_pipe_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned GROUP  = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef CLA_PIPE_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             g_out,
    output logic             p_out,
    output logic             ovf
);

    localparam int unsigned SEG  = WIDTH / STAGES;
    localparam int unsigned NGRP = SEG / GROUP;
    localparam int unsigned RW   = SEG + 4;

    // One segment CLA: returns {seg_g, seg_p, carry_into_msb, carry_out, sum}.
    function automatic logic [RW-1:0] seg_add(input logic [SEG-1:0] x,
                                              input logic [SEG-1:0] y,
                                              input logic           cin);
        logic [SEG-1:0] g;
        logic [SEG-1:0] p;
        logic [SEG-1:0] sum;
        logic           c;
        logic           cg;
        logic           gg;
        logic           gp;
        logic           seg_g;
        logic           seg_p;
        logic           c_msb;
        int unsigned    idx;
        g     = x & y;
        p     = x ^ y;
        sum   = '0;
        c     = cin;
        seg_g = 1'b0;
        seg_p = 1'b1;
        c_msb = 1'b0;
        for (int unsigned j = 0; j < NGRP; j++) begin
            gg = 1'b0;
            gp = 1'b1;
            cg = c;
            for (int unsigned i = 0; i < GROUP; i++) begin
                idx      = j * GROUP + i;
                sum[idx] = p[idx] ^ cg;
                c_msb    = cg;
                cg       = g[idx] | (p[idx] & cg);
                gg       = g[idx] | (p[idx] & gg);
                gp       = gp & p[idx];
            end
            // Group carry is resolved from the group G/P, not from the in-group chain.
            c     = gg | (gp & c);
            seg_g = gg | (gp & seg_g);
            seg_p = seg_p & gp;
        end
        return {seg_g, seg_p, c_msb, c, sum};
    endfunction

    logic             st_v [STAGES];
    logic [WIDTH-1:0] st_s [STAGES];
    logic [WIDTH-1:0] st_a [STAGES];
    logic [WIDTH-1:0] st_b [STAGES];
    logic             st_c [STAGES];
    logic             st_g [STAGES];
    logic             st_p [STAGES];
    logic             st_o [STAGES];

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    assign advance  = !st_v[STAGES-1] || out_ready;
    assign in_ready = advance;

`ifdef CLA_PIPE_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | c_in;
`else
    assign b_eff   = b;
    assign cin_eff = c_in;
`endif

    // Each stage adds the segment at the bottom of the remaining operands, then shifts them down.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG-1:0]   x;
        logic [SEG-1:0]   y;
        logic             ci;
        logic             prev_v;
        logic             prev_g;
        logic             prev_p;
        logic [WIDTH-1:0] prev_s;
        logic [WIDTH-1:0] rem_a;
        logic [WIDTH-1:0] rem_b;
        logic [RW-1:0]    r;

        if (k == 0) begin : g_first
            assign rem_a  = a;
            assign rem_b  = b_eff;
            assign ci     = cin_eff;
            assign prev_v = in_valid;
            assign prev_s = '0;
            assign prev_g = 1'b0;
            assign prev_p = 1'b1;
        end else begin : g_next
            assign rem_a  = st_a[k-1];
            assign rem_b  = st_b[k-1];
            assign ci     = st_c[k-1];
            assign prev_v = st_v[k-1];
            assign prev_s = st_s[k-1];
            assign prev_g = st_g[k-1];
            assign prev_p = st_p[k-1];
        end

        assign x = rem_a[SEG-1:0];
        assign y = rem_b[SEG-1:0];
        assign r = seg_add(x, y, ci);

        always_ff @(posedge clk) begin
            if (!resetn) begin
                st_v[k] <= 1'b0;
                st_s[k] <= '0;
                st_a[k] <= '0;
                st_b[k] <= '0;
                st_c[k] <= 1'b0;
                st_g[k] <= 1'b0;
                st_p[k] <= 1'b0;
                st_o[k] <= 1'b0;
            end else if (advance) begin
                st_v[k] <= prev_v;
                st_s[k] <= prev_s | (WIDTH'(r[SEG-1:0]) << (k * SEG));
                st_a[k] <= rem_a >> SEG;
                st_b[k] <= rem_b >> SEG;
                st_c[k] <= r[SEG];
                st_o[k] <= r[SEG+1] ^ r[SEG];
                st_p[k] <= r[SEG+2] & prev_p;
                st_g[k] <= r[SEG+3] | (r[SEG+2] & prev_g);
            end
        end
    end

    assign out_valid = st_v[STAGES-1];
    assign s         = st_s[STAGES-1];
    assign c_out     = st_c[STAGES-1];
    assign g_out     = st_g[STAGES-1];
    assign p_out     = st_p[STAGES-1];
    assign ovf       = st_o[STAGES-1];

endmodule
